// File: rtl/merge_logic.sv
// Two-stream merge: pops one upstream FIFO per cycle, forwards its word two edges later,
// drops words whose class bit disagrees with their source. Optional MERGE_ROUND_ROBIN_EN.
module merge_logic #(
  parameter int data_width = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  D0_empty,
  input  logic                  D1_empty,
  input  logic [data_width-1:0] data_in_D0,
  input  logic [data_width-1:0] data_in_D1,
  input  logic                  out_full,
  output logic                  D0_pop,
  output logic                  D1_pop,
  output logic [data_width-1:0] data_out,
  output logic                  valid_out,
  output logic                  error_out,
  output logic [7:0]            word_count
);

  // Handshake: a pop in cycle k is a request; the FIFO presents the word on
  // data_in_Dx during cycle k+1, and it leaves here on data_out/valid_out in k+2.
  logic                  pend_valid;
  logic                  pend_src;
  logic [data_width-1:0] pend_word;
  logic                  class_ok;
  logic                  both_ready;

  assign both_ready = !D0_empty && !D1_empty;

`ifdef MERGE_ROUND_ROBIN_EN
  logic rr_ptr;

  // Pointer names the source that wins the next tie; it moves away from whoever was just served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
    end else if (D0_pop) begin
      rr_ptr <= 1'b1;
    end else if (D1_pop) begin
      rr_ptr <= 1'b0;
    end
  end

  always_comb begin
    D0_pop = 1'b0;
    D1_pop = 1'b0;
    if (reset && !out_full) begin
      if (both_ready) begin
        D0_pop = !rr_ptr;
        D1_pop = rr_ptr;
      end else begin
        D0_pop = !D0_empty;
        D1_pop = !D1_empty;
      end
    end
  end
`else
  always_comb begin
    D0_pop = 1'b0;
    D1_pop = 1'b0;
    if (reset && !out_full) begin
      if (both_ready) begin
        D0_pop = 1'b1;
      end else begin
        D0_pop = !D0_empty;
        D1_pop = !D1_empty;
      end
    end
  end
`endif

  assign pend_word = pend_src ? data_in_D1 : data_in_D0;
  assign class_ok  = (pend_word[data_width-1] == pend_src);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_src   <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      error_out  <= 1'b0;
      word_count <= 8'd0;
    end else begin
      pend_valid <= D0_pop || D1_pop;
      pend_src   <= D1_pop;
      valid_out  <= pend_valid && class_ok;
      error_out  <= pend_valid && !class_ok;
      if (pend_valid && class_ok) begin
        data_out   <= pend_word;
        word_count <= word_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_merge_logic.sv
// Bench for merge_logic: arbitration vector table, directed multi-cycle sequences,
// and randomized traffic against a queue-based reference model.
module tb_merge_logic;
  localparam int W = 6;

  logic         clk;
  logic         reset;
  logic         D0_empty;
  logic         D1_empty;
  logic [W-1:0] data_in_D0;
  logic [W-1:0] data_in_D1;
  logic         out_full;
  logic         D0_pop;
  logic         D1_pop;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         error_out;
  logic [7:0]   word_count;

  merge_logic #(.data_width(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .D0_empty   (D0_empty),
    .D1_empty   (D1_empty),
    .data_in_D0 (data_in_D0),
    .data_in_D1 (data_in_D1),
    .out_full   (out_full),
    .D0_pop     (D0_pop),
    .D1_pop     (D1_pop),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .error_out  (error_out),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Upstream FIFO contents, scoreboard and observation logs
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           got_cyc[$];
  int           err_cyc[$];

  // Reference model state
  int           m_ptr;
  int           m_count;
  bit           m_pv;
  bit           m_ps;
  logic [W-1:0] m_pw;
  logic [W-1:0] m_last;
  int           cyc;

  typedef struct {
    logic rst;
    logic d0e;
    logic d1e;
    logic full;
    logic e0;
    logic e1;
  } vec_t;
  vec_t tbl[8];

  logic [W-1:0] exp_order[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; asserts reset, checks cleared outputs, releases at a falling edge.
  task automatic do_reset();
    D0_empty = 1'b0;
    D1_empty = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_error_out", error_out, 0);
    check("rst_word_count", word_count, 0);
    check("rst_D0_pop", D0_pop, 0);
    check("rst_D1_pop", D1_pop, 0);
    @(negedge clk);
    @(negedge clk);
    q0.delete(); q1.delete(); exp_q.delete(); got_q.delete(); got_cyc.delete(); err_cyc.delete();
    m_ptr = 0; m_count = 0; m_pv = 0; m_ps = 0; m_pw = '0; m_last = '0; cyc = 0;
    D0_empty = 1'b1;
    D1_empty = 1'b1;
    out_full = 1'b0;
    reset = 1'b1;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic run_cycle();
    bit e0, e1, mp0, mp1, ok;
    logic [W-1:0] w;
    D0_empty = (q0.size() == 0);
    D1_empty = (q1.size() == 0);
    #1;
    e0 = (q0.size() > 0);
    e1 = (q1.size() > 0);
    mp0 = 0;
    mp1 = 0;
    if (!out_full) begin
      if (e0 && e1) begin
`ifdef MERGE_ROUND_ROBIN_EN
        if (m_ptr == 0) mp0 = 1; else mp1 = 1;
`else
        mp0 = 1;
`endif
      end else begin
        mp0 = e0;
        mp1 = e1;
      end
    end
    check("D0_pop", D0_pop, mp0);
    check("D1_pop", D1_pop, mp1);

    @(posedge clk);
    #1;
    ok = m_pv && (m_pw[W-1] == m_ps);
    if (ok) begin
      m_count = (m_count + 1) % 256;
      m_last = m_pw;
    end
    check("valid_out", valid_out, ok);
    check("error_out", error_out, m_pv && !ok);
    check("word_count", word_count, m_count);
    if (valid_out) begin
      got_q.push_back(data_out);
      got_cyc.push_back(cyc + 1);
      if (exp_q.size() > 0) begin
        check("data_out", data_out, exp_q.pop_front());
      end else begin
        n_cmp++;
        n_bad++;
        $display("FAIL data_out: got unexpected word %0h expected none (t=%0t)", data_out, $time);
      end
    end else begin
      check("data_out_hold", data_out, m_last);
    end
    if (error_out) err_cyc.push_back(cyc + 1);

    m_pv = mp0 || mp1;
    m_ps = mp1;
    if (mp0) begin
      w = q0.pop_front();
      data_in_D0 = w;
      m_pw = w;
      m_ptr = 1;
    end else begin
      data_in_D0 = W'($urandom);
    end
    if (mp1) begin
      w = q1.pop_front();
      data_in_D1 = w;
      m_pw = w;
      m_ptr = 0;
    end else begin
      data_in_D1 = W'($urandom);
    end
    if (m_pv && (m_pw[W-1] == m_ps)) exp_q.push_back(m_pw);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef MERGE_ROUND_ROBIN_EN
    exp_order = '{6'd1, 6'd33, 6'd2, 6'd34, 6'd3, 6'd35, 6'd4, 6'd36};
`else
    exp_order = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd33, 6'd34, 6'd35, 6'd36};
`endif

    reset = 1'b0;
    D0_empty = 1'b1;
    D1_empty = 1'b1;
    out_full = 1'b0;
    data_in_D0 = '0;
    data_in_D1 = '0;
    @(negedge clk);
    do_reset();

    // Arbitration table with the pointer at its reset value; restored before the rising edge.
    for (int i = 0; i < 8; i++) begin
      reset = tbl[i].rst;
      D0_empty = tbl[i].d0e;
      D1_empty = tbl[i].d1e;
      out_full = tbl[i].full;
      #1;
      check($sformatf("tbl%0d_D0_pop", i), D0_pop, tbl[i].e0);
      check($sformatf("tbl%0d_D1_pop", i), D1_pop, tbl[i].e1);
      #1;
      D0_empty = 1'b1;
      D1_empty = 1'b1;
      out_full = 1'b0;
      reset = 1'b1;
      @(negedge clk);
    end

    // Single D0 word: pop in cycle 0, delivered in cycle 2
    do_reset();
    q0.push_back(6'b000001);
    for (int i = 0; i < 4; i++) run_cycle();
    check("single_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check("single_word", got_q[0], 6'b000001);
      check("single_cycle", got_cyc[0], 2);
    end
    check("single_word_count", word_count, 1);

    // Four words in each FIFO, merged back to back
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      q0.push_back(W'(i));
      q1.push_back(W'(32 + i));
    end
    for (int i = 0; i < 12; i++) run_cycle();
    check("burst_count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) begin
        check($sformatf("burst_word%0d", i), got_q[i], exp_order[i]);
        check($sformatf("burst_cycle%0d", i), got_cyc[i], 2 + i);
      end
    end
    check("burst_word_count", word_count, 8);

    // Class mismatch on D0 stream
    do_reset();
    q0.push_back(6'b100011);
    for (int i = 0; i < 4; i++) run_cycle();
    check("mis_err_pulses", err_cyc.size(), 1);
    if (err_cyc.size() == 1) check("mis_err_cycle", err_cyc[0], 2);
    check("mis_no_valid", got_q.size(), 0);
    check("mis_word_count", word_count, 0);

    // Backpressure right after a pop: pending word still delivered
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      q0.push_back(W'(i));
      q1.push_back(W'(32 + i));
    end
    run_cycle();
    out_full = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle();
    out_full = 1'b0;
    check("full_pending_delivered", got_q.size(), 1);
    for (int i = 0; i < 10; i++) run_cycle();
    check("full_total", got_q.size(), 6);
    if (got_q.size() >= 2) begin
      check("full_first_cycle", got_cyc[0], 2);
      check("full_resume_cycle", got_cyc[1], 6);
    end

    // Reset one cycle after a pop while a word is pending
    do_reset();
    q0.push_back(6'd1);
    q0.push_back(6'd2);
    q0.push_back(6'd3);
    for (int i = 0; i < 3; i++) run_cycle();
    check("pre_reset_valid", valid_out, 1);
    do_reset();
    for (int i = 0; i < 4; i++) run_cycle();
    check("post_reset_no_valid", got_q.size(), 0);
    check("post_reset_no_error", err_cyc.size(), 0);

    // Randomized traffic including backpressure, mismatches and count wrap
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) != 0 && q0.size() < 8)
        q0.push_back({($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, 5'($urandom)});
      if ($urandom_range(0, 3) != 0 && q1.size() < 8)
        q1.push_back({($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1, 5'($urandom)});
      out_full = ($urandom_range(0, 4) == 0);
      run_cycle();
    end
    out_full = 1'b0;
    for (int i = 0; i < 24; i++) run_cycle();
    check("rand_scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/merge_logic.md
MERGE_LOGIC -- requirements
Module: merge_logic

Interface
REQ-001 SHALL have parameter data_width, default 6, meaning word width; bit [data_width-1] is the class bit (0 = D0 stream, 1 = D1 stream).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low; reset=0 clears all state immediately, reset=1 is normal operation.
REQ-004 SHALL have port D0_empty  input  1  upstream D0 FIFO has no words.
REQ-005 SHALL have port D1_empty  input  1  upstream D1 FIFO has no words.
REQ-006 SHALL have port data_in_D0  input  data_width  D0 FIFO read data, valid the cycle after a D0_pop cycle.
REQ-007 SHALL have port data_in_D1  input  data_width  D1 FIFO read data, same timing as data_in_D0.
REQ-008 SHALL have port out_full  input  1  downstream cannot accept a new pop this cycle.
REQ-009 SHALL have port D0_pop  output  1  combinational pop request to D0 FIFO.
REQ-010 SHALL have port D1_pop  output  1  combinational pop request to D1 FIFO.
REQ-011 SHALL have port data_out  output  data_width  merged word, registered.
REQ-012 SHALL have port valid_out  output  1  data_out holds a new word this cycle, registered.
REQ-013 SHALL have port error_out  output  1  one-cycle registered pulse on class-bit mismatch.
REQ-014 SHALL have port word_count  output  8  registered count of words forwarded.

Function
REQ-015 SHALL assert at most one of D0_pop/D1_pop per cycle, never both.
REQ-016 SHALL drive both pops 0 when out_full=1 or reset=0.
REQ-017 SHALL be eligible to pop Dx only when Dx_empty=0.
REQ-018 SHALL choose by arbitration (REQ-031/032) when both D0 and D1 are eligible; a single eligible source is popped directly.
REQ-019 SHALL record the popped source in a pending register at the edge ending the pop cycle k.
REQ-020 SHALL, at the edge ending cycle k+1, load data_out from the pending source's data_in, set valid_out=1; latency = 2 edges from pop cycle.
REQ-021 SHALL support a pop every cycle (fully pipelined, throughput 1 word/cycle).
REQ-022 SHALL clear valid_out in any cycle with no pending word; data_out holds its last value.
REQ-023 SHALL flag a mismatch when a D0 word has class bit 1 or a D1 word has class bit 0: error_out=1 for one cycle, the word is dropped (valid_out=0), word_count unchanged.
REQ-024 SHALL increment word_count by 1 per forwarded word, wrapping 255 -> 0.
REQ-025 SHALL complete an already pending word even if out_full rises in the following cycle.

Reset
REQ-026 SHALL, while reset=0, force data_out=0, valid_out=0, error_out=0, word_count=0, D0_pop=0, D1_pop=0.
REQ-027 SHALL clear the pending register and arbitration pointer to D0 on reset.
REQ-028 SHALL discard a pending word when reset asserts mid-operation (no valid_out after release).
REQ-029 SHALL allow the first pop in the first cycle with reset=1.

Configuration
REQ-030 SHALL use macro MERGE_ROUND_ROBIN_EN.
REQ-031 SHALL, with MERGE_ROUND_ROBIN_EN defined, alternate when both eligible: pointer toggles after each pop; after reset D0 wins first.
REQ-032 SHALL, without MERGE_ROUND_ROBIN_EN, give fixed priority to D0; D1 pops only when D0_empty=1.

Verification
REQ-033 SHALL test: reset release, D0 holds 6'b000001, D1 empty, out_full=0 -> D0_pop=1 in cycle 0, data_out=6'b000001, valid_out=1 in cycle 2, word_count=1.
REQ-034 SHALL test: both FIFOs hold 4 words (000001..000100 / 100001..100100), round-robin -> valid_out high 8 consecutive cycles, order 000001,100001,000010,100010,...; word_count=8.
REQ-035 SHALL test: same stimulus without MERGE_ROUND_ROBIN_EN -> four D0 words then four D1 words.
REQ-036 SHALL test: D0 FIFO presents 6'b100011 -> error_out pulse one cycle, valid_out=0, word_count unchanged.
REQ-037 SHALL test: out_full=1 for 3 cycles with both non-empty -> no pops, pending word still delivered, resumes when out_full=0.
REQ-038 SHALL test: reset=0 asserted one cycle after a pop -> all outputs 0 immediately, no valid_out after release.
